// File: rtl/arm_inst_classify_fifo_if.sv
// Purpose: producer/consumer handshake bundle for arm_inst_classify_fifo.
// Ports: in_* carry the instruction word in; out_* carry the classified head out.
// The master modport is the producer/consumer side; the slave modport is the classifier FIFO.
interface arm_inst_classify_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_instype;
  logic [2:0]  out_datainstype;
  logic [3:0]  out_cond;
  logic        out_nv;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_inst, out_instype, out_datainstype, out_cond, out_nv
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_inst, out_instype, out_datainstype, out_cond, out_nv
  );
endinterface

// File: rtl/arm_inst_classify_fifo.sv
// Purpose: classifies 32-bit ARM instruction words, queues them in a DEPTH-entry FIFO and
//          keeps saturating per-class counters. Ports: clk/rst, bus (slave handshake), count_clr,
//          cnt_dp/cnt_ls/cnt_br/cnt_other, level. Latency: 1 cycle push-to-head.
// Backpressure: in_ready drops when level == DEPTH (no full-bypass); head holds while out_ready=0.
module arm_inst_classify_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  arm_inst_classify_fifo_if.slave bus,
  input  logic                   count_clr,
  output logic [CNT_W-1:0]       cnt_dp,
  output logic [CNT_W-1:0]       cnt_ls,
  output logic [CNT_W-1:0]       cnt_br,
  output logic [CNT_W-1:0]       cnt_other,
  output logic [LVL_W-1:0]       level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Classification of the incoming word (stored at push only)
  logic [1:0] w_instype;
  logic [2:0] w_datainstype;

  always_comb begin
    w_instype     = 2'd0;
    w_datainstype = 3'd0;
    unique case (bus.in_inst[27:26])
      2'b00: w_instype = 2'd1;
      2'b01: w_instype = 2'd2;
      2'b10: w_instype = 2'd3;
      default: w_instype = 2'd0;
    endcase
    // Subtype only meaningful for data processing; forced to 0 otherwise
    if (w_instype == 2'd1) begin
      if (bus.in_inst[25])
        w_datainstype = 3'd1;
      else if (!bus.in_inst[4])
        w_datainstype = 3'd2;
      else if (!bus.in_inst[7])
        w_datainstype = 3'd3;
      else if (!bus.in_inst[24] && (bus.in_inst[6:5] == 2'b00))
        w_datainstype = 3'd4;
      else
        w_datainstype = 3'd0;
    end
  end

  // FIFO state
  logic [31:0]      r_mem_inst  [DEPTH];
  logic [1:0]       r_mem_type  [DEPTH];
  logic [2:0]       r_mem_dtype [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  // Holds in_ready low until the first clock edge after reset release
  logic             r_live;

  logic w_push;
  logic w_pop;

  assign bus.in_ready  = r_live && (r_level < FULL_LVL);
  assign bus.out_valid = (r_level != '0);
  assign w_push        = bus.in_valid && bus.in_ready;
  assign w_pop         = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset: contents are meaningless once the pointers are cleared
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr]  <= bus.in_inst;
      r_mem_type[r_wr_ptr]  <= w_instype;
      r_mem_dtype[r_wr_ptr] <= w_datainstype;
    end
  end

  assign bus.out_inst        = r_mem_inst[r_rd_ptr];
  assign bus.out_instype     = r_mem_type[r_rd_ptr];
  assign bus.out_datainstype = r_mem_dtype[r_rd_ptr];
  assign bus.out_cond        = r_mem_inst[r_rd_ptr][31:28];
  assign bus.out_nv          = (r_mem_inst[r_rd_ptr][31:28] == 4'hF);
  assign level               = r_level;

  // Saturating instruction-mix counters; clear wins over a same-cycle push
  logic [CNT_W-1:0] r_cnt_dp;
  logic [CNT_W-1:0] r_cnt_ls;
  logic [CNT_W-1:0] r_cnt_br;
  logic [CNT_W-1:0] r_cnt_other;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_dp    <= '0;
      r_cnt_ls    <= '0;
      r_cnt_br    <= '0;
      r_cnt_other <= '0;
    end else if (count_clr) begin
      r_cnt_dp    <= '0;
      r_cnt_ls    <= '0;
      r_cnt_br    <= '0;
      r_cnt_other <= '0;
    end else if (w_push) begin
      case (w_instype)
        2'd1:    if (r_cnt_dp    != '1) r_cnt_dp    <= r_cnt_dp    + CNT_W'(1);
        2'd2:    if (r_cnt_ls    != '1) r_cnt_ls    <= r_cnt_ls    + CNT_W'(1);
        2'd3:    if (r_cnt_br    != '1) r_cnt_br    <= r_cnt_br    + CNT_W'(1);
        default: if (r_cnt_other != '1) r_cnt_other <= r_cnt_other + CNT_W'(1);
      endcase
    end
  end

  assign cnt_dp    = r_cnt_dp;
  assign cnt_ls    = r_cnt_ls;
  assign cnt_br    = r_cnt_br;
  assign cnt_other = r_cnt_other;

endmodule

// File: tb/tb_arm_inst_classify_fifo.sv
// Purpose: self-checking bench for arm_inst_classify_fifo (DEPTH=4, CNT_W=4).
// Stimulus driven on the falling edge, outputs sampled on the falling edge.
// A queue-based model supplies every expected value.
module tb_arm_inst_classify_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             count_clr = 1'b0;
  logic [CNT_W-1:0] cnt_dp, cnt_ls, cnt_br, cnt_other;
  logic [LVL_W-1:0] level;

  arm_inst_classify_fifo_if bus();

  arm_inst_classify_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .count_clr(count_clr),
    .cnt_dp(cnt_dp), .cnt_ls(cnt_ls), .cnt_br(cnt_br), .cnt_other(cnt_other),
    .level(level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [31:0] mq[$];
  int          m_cnt[4];
  bit          m_en = 0;

  // Expected {inst, instype, datainstype, cond, nv} for a word
  function automatic logic [41:0] exp_head(input logic [31:0] w);
    logic [1:0] t;
    logic [2:0] d;
    t = 2'((int'(w[27:26]) + 1) % 4);
    d = 3'd0;
    if (t == 2'd1) begin
      if (w[25] == 1'b1)                        d = 3'd1;
      else if (w[4] == 1'b0)                    d = 3'd2;
      else if (w[7] == 1'b0)                    d = 3'd3;
      else if (w[24] == 1'b0 && w[6:5] == 2'd0) d = 3'd4;
    end
    return {w, t, d, w[31:28], (w[31:28] == 4'hF)};
  endfunction

  function automatic logic [41:0] dut_head();
    return {bus.out_inst, bus.out_instype, bus.out_datainstype, bus.out_cond, bus.out_nv};
  endfunction

  function automatic logic [15:0] exp_cnts();
    return {4'(m_cnt[1]), 4'(m_cnt[2]), 4'(m_cnt[3]), 4'(m_cnt[0])};
  endfunction

  // One clock of stimulus; advances the model, makes no comparisons
  task automatic drive_cycle(input bit v, input logic [31:0] w, input bit ordy, input bit clr);
    bit push, pop;
    logic [1:0] t;
    bus.in_valid  = v;
    bus.in_inst   = w;
    bus.out_ready = ordy;
    count_clr     = clr;
    push = v && m_en && (mq.size() < DEPTH);
    pop  = ordy && (mq.size() > 0);
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(w);
    t = 2'((int'(w[27:26]) + 1) % 4);
    if (clr) foreach (m_cnt[i]) m_cnt[i] = 0;
    else if (push && m_cnt[t] < CMAX) m_cnt[t]++;
    m_en = 1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    count_clr     = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_inst = '0; bus.out_ready = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid, level} !== {1'b0, 1'b0, 3'd0}) begin
      bad++; $display("FAIL reset_ctrl got rdy/vld/lvl=%b/%b/%0d want 0/0/0", bus.in_ready, bus.out_valid, level);
    end
    total++;
    if ({cnt_dp, cnt_ls, cnt_br, cnt_other} !== 16'h0) begin
      bad++; $display("FAIL reset_cnt got %h want 0000", {cnt_dp, cnt_ls, cnt_br, cnt_other});
    end
    rst = 0;
    mq.delete(); foreach (m_cnt[i]) m_cnt[i] = 0; m_en = 0;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge got %b want 0", bus.in_ready);
    end
    drive_cycle(0, '0, 0, 0);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_edge got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    drive_cycle(1, 32'hE2811001, 0, 0);
    total++;
    if (bus.out_valid !== 1'b1 || level !== 3'd1) begin
      bad++; $display("FAIL single_vld got vld=%b lvl=%0d want 1/1", bus.out_valid, level);
    end
    total++;
    if (dut_head() !== {32'hE2811001, 2'd1, 3'd1, 4'hE, 1'b0}) begin
      bad++; $display("FAIL single_head got %h want %h", dut_head(), {32'hE2811001, 2'd1, 3'd1, 4'hE, 1'b0});
    end
    total++;
    if (cnt_dp !== 4'd1) begin
      bad++; $display("FAIL single_cnt_dp got %0d want 1", cnt_dp);
    end
  endtask

  // Pops everything, checking order/classification of each head
  task automatic drain_and_check(input string tag);
    int guard = 0;
    while (mq.size() > 0 && guard < 4 * DEPTH) begin
      total++;
      if (bus.out_valid !== 1'b1 || dut_head() !== exp_head(mq[0])) begin
        bad++; $display("FAIL %s_drain got vld=%b %h want 1 %h", tag, bus.out_valid, dut_head(), exp_head(mq[0]));
      end
      drive_cycle(0, '0, 1, 0);
      guard++;
    end
    total++;
    if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
      bad++; $display("FAIL %s_empty got vld=%b lvl=%0d want 0/0", tag, bus.out_valid, level);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4] = '{32'hE0010392, 32'hE0811312, 32'hE5912000, 32'hEA000010};
    logic [2:0]  dtype [4] = '{3'd4, 3'd3, 3'd0, 3'd0};
    logic [1:0]  itype [4] = '{2'd1, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || dut_head() !== exp_head(mq[0])) begin
        bad++; $display("FAIL b2b_head%0d got %h want %h", i, dut_head(), exp_head(mq[0]));
      end
      drive_cycle(1, words[i], 1, 0);
      total++;
      if (level !== 3'd1) begin
        bad++; $display("FAIL b2b_level%0d got %0d want 1", i, level);
      end
      total++;
      if ({bus.out_inst, bus.out_instype, bus.out_datainstype} !== {words[i], itype[i], dtype[i]}) begin
        bad++; $display("FAIL b2b_class%0d got %h/%0d/%0d want %h/%0d/%0d", i, bus.out_inst,
                        bus.out_instype, bus.out_datainstype, words[i], itype[i], dtype[i]);
      end
    end
    total++;
    if ({cnt_dp, cnt_ls, cnt_br} !== {4'd3, 4'd1, 4'd1}) begin
      bad++; $display("FAIL b2b_cnts got dp=%0d ls=%0d br=%0d want 3/1/1", cnt_dp, cnt_ls, cnt_br);
    end
    drain_and_check("b2b");
  endtask

  task automatic test_full();
    logic [31:0] w;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = $urandom;
      total++;
      if (bus.in_ready !== (mq.size() < DEPTH)) begin
        bad++; $display("FAIL full_ready%0d got %b want %b", i, bus.in_ready, mq.size() < DEPTH);
      end
      drive_cycle(1, w, 0, 0);
    end
    total++;
    if (level !== 3'(DEPTH) || bus.in_ready !== 1'b0 || mq.size() != DEPTH) begin
      bad++; $display("FAIL full_level got lvl=%0d rdy=%b want %0d/0", level, bus.in_ready, DEPTH);
    end
    // Push attempt plus pop while full: the push must be refused
    drive_cycle(1, 32'hDEADBEEF, 1, 0);
    total++;
    if (level !== 3'(DEPTH - 1) || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL full_pop got lvl=%0d rdy=%b want %0d/1", level, bus.in_ready, DEPTH - 1);
    end
    drive_cycle(1, 32'h0A5A5A5A, 0, 0);
    drain_and_check("full");
  endtask

  task automatic test_nv_other();
    int oth;
    oth = m_cnt[0];
    drive_cycle(1, 32'hFA000000, 0, 0);
    total++;
    if ({bus.out_instype, bus.out_nv, bus.out_cond} !== {2'd3, 1'b1, 4'hF}) begin
      bad++; $display("FAIL nv_head got type=%0d nv=%b cond=%h want 3/1/f", bus.out_instype, bus.out_nv, bus.out_cond);
    end
    drive_cycle(1, 32'hEE000000, 1, 0);
    total++;
    if ({bus.out_instype, bus.out_datainstype, bus.out_nv} !== {2'd0, 3'd0, 1'b0}) begin
      bad++; $display("FAIL other_head got type=%0d dt=%0d nv=%b want 0/0/0", bus.out_instype, bus.out_datainstype, bus.out_nv);
    end
    total++;
    if (cnt_other !== 4'(oth + 1)) begin
      bad++; $display("FAIL other_cnt got %0d want %0d", cnt_other, oth + 1);
    end
    drain_and_check("nv");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) drive_cycle(1, $urandom & 32'hF3FFFFFF, 1, 0);
    total++;
    if (cnt_dp !== 4'd15) begin
      bad++; $display("FAIL sat_dp got %0d want 15", cnt_dp);
    end
    drive_cycle(1, 32'hE5912000, 1, 1);
    total++;
    if ({cnt_dp, cnt_ls, cnt_br, cnt_other} !== 16'h0) begin
      bad++; $display("FAIL clr_cnts got %h want 0000", {cnt_dp, cnt_ls, cnt_br, cnt_other});
    end
    total++;
    if (dut_head() !== exp_head(32'hE5912000)) begin
      bad++; $display("FAIL clr_push got %h want %h", dut_head(), exp_head(32'hE5912000));
    end
    drain_and_check("sat");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      total++;
      if (level !== 3'(mq.size()) || bus.out_valid !== (mq.size() != 0) ||
          bus.in_ready !== (m_en && mq.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_ctrl c=%0d got lvl=%0d vld=%b rdy=%b want %0d", c, level, bus.out_valid,
                        bus.in_ready, mq.size());
      end
      total++;
      if ({cnt_dp, cnt_ls, cnt_br, cnt_other} !== exp_cnts()) begin
        bad++; $display("FAIL rnd_cnts c=%0d got %h want %h", c, {cnt_dp, cnt_ls, cnt_br, cnt_other}, exp_cnts());
      end
      if (mq.size() > 0) begin
        total++;
        if (dut_head() !== exp_head(mq[0])) begin
          bad++; $display("FAIL rnd_head c=%0d got %h want %h", c, dut_head(), exp_head(mq[0]));
        end
      end
      drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    drain_and_check("rnd");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive_cycle(1, $urandom, 0, 0);
    total++;
    if (level !== 3'd3) begin
      bad++; $display("FAIL mid_prefill got %0d want 3", level);
    end
    #2 rst = 1;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready, level, cnt_dp, cnt_ls, cnt_br, cnt_other} !== 21'h0) begin
      bad++; $display("FAIL mid_reset got vld=%b rdy=%b lvl=%0d cnts=%h want all 0", bus.out_valid,
                      bus.in_ready, level, {cnt_dp, cnt_ls, cnt_br, cnt_other});
    end
    @(negedge clk);
    rst = 0;
    mq.delete(); foreach (m_cnt[i]) m_cnt[i] = 0; m_en = 0;
    drive_cycle(0, '0, 0, 0);
    drive_cycle(1, 32'h13579BDF, 0, 0);
    drive_cycle(1, 32'h2468ACE0, 0, 0);
    total++;
    if (level !== 3'd2 || dut_head() !== exp_head(32'h13579BDF)) begin
      bad++; $display("FAIL mid_first got lvl=%0d %h want 2 %h", level, dut_head(), exp_head(32'h13579BDF));
    end
    drain_and_check("mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_nv_other();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_inst_classify_fifo.md
Name: arm_inst_classify_fifo

Overview:
- Parametrised successor to the ARM instruction-class decoder.
- Accepts 32-bit ARM instruction words over a valid/ready handshake and classifies each word: major type, data-processing subtype, condition field.
- Buffers the decoded results in a DEPTH-entry FIFO for the downstream execute-stage model.
- Keeps saturating per-class statistics counters for the instruction-mix monitor.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of each statistics counter.
- LVL_W, $clog2(DEPTH+1), width of the level output (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has an instruction.
- in_ready  out  1  block can accept; high when level < DEPTH.
- in_inst  in  32  ARM instruction word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_inst  out  32  head instruction word.
- out_instype  out  2  major class of head.
- out_datainstype  out  3  data-processing subtype of head.
- out_cond  out  4  head inst[31:28].
- out_nv  out  1  head cond == 4'b1111 (unconditional/NV space).
- count_clr  in  1  synchronous clear of all counters.
- cnt_dp  out  CNT_W  accepted class-1 count.
- cnt_ls  out  CNT_W  accepted class-2 count.
- cnt_br  out  CNT_W  accepted class-3 count.
- cnt_other  out  CNT_W  accepted class-0 count.
- level  out  LVL_W  current FIFO occupancy.

Behaviour:
- Classification is combinational on in_inst and is stored at push. No combinational path exists from in_inst to any output.
- instype from inst[27:26]:
  - 00 -> 1 (data processing)
  - 01 -> 2 (load/store)
  - 10 -> 3 (branch/block transfer)
  - 11 -> 0 (coprocessor/SWI)
- datainstype is evaluated only when instype == 1, in priority order:
  - inst[25]=1 -> 1 (immediate operand)
  - else inst[4]=0 -> 2 (register, immediate shift)
  - else inst[7]=0 -> 3 (register, register shift)
  - else inst[24]=0 and inst[6:5]=00 -> 4 (multiply)
  - else -> 0
- datainstype is 0 for all other instypes; it is never left stale.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (level < DEPTH). When full, in_ready=0 even if a pop occurs the same cycle; there is no full-bypass.
- out_valid = (level != 0). The head outputs are driven from the FIFO read pointer.
- Latency: a word pushed into an empty FIFO at edge N is presented with out_valid=1 after edge N. Minimum latency is 1 cycle; sustained throughput is 1 word/cycle when not full.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level is a separate counter in 0..DEPTH.
- Head outputs hold their values while out_valid=1 and out_ready=0.
- Head outputs when empty: out_valid=0, other head fields don't-care. The bench must not check them.
- Counters:
  - On each push, the counter matching the pushed instype increments by 1.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - count_clr=1 zeroes all four counters that cycle and has priority; a push in that same cycle is not counted.
- Reset (async assert, any time, including mid-stream) forces:
  - level=0, pointers=0, out_valid=0, in_ready=0 while rst=1;
  - all counters = 0.
  - FIFO contents are discarded.
  - in_ready rises on the first clk edge after rst deasserts.

Test Plan:
- Reset, then push 0xE2811001 (data-processing immediate) -> out_valid=1 the next cycle; instype=1, datainstype=1, cond=0xE, out_nv=0; cnt_dp=1.
- Push back-to-back with out_ready=1: 0xE0010392 (MUL), 0xE0811312 (register-shift-by-register), 0xE5912000 (LDR), 0xEA000010 (B) -> datainstype 4, 3, then instype 2 and 3 with datainstype=0; in-order delivery, 1/cycle; cnt_ls=1, cnt_br=1.
- out_ready=0, push DEPTH+1 words -> in_ready drops after DEPTH pushes, level=DEPTH, extra word not accepted; then one pop -> in_ready=1 the next cycle, FIFO order intact after pointer wrap.
- Push 0xFA000000 -> instype=3, out_nv=1. Push 0xEE000000 -> instype=0, cnt_other increments.
- CNT_W=4: push 20 data-processing words -> cnt_dp sticks at 15. Assert count_clr with a simultaneous push -> all counters 0.
- Assert rst mid-stream with level=3 -> out_valid=0, level=0, counters 0 immediately. After deassert, the first word pushed is the first word out.
